// File: rtl/synth_pkg.sv
// Shared definitions for the sine voice scheduler.
//   state_t    : sweep FSM states
//   LUT_ADDR_W : sine LUT address width (top phase bits)
//   AMP_W      : unsigned LUT amplitude width
//   AMP_MID    : amplitude midpoint, subtracted to get a signed sample
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LUT_ADDR_W = 6;
  localparam int AMP_W      = 8;
  localparam int AMP_MID    = 128;

endpackage

// File: rtl/sine_lut.sv
// 64-entry sine lookup table with a registered output (1-cycle latency).
// Amplitude is offset binary: 128 + floor(128*sin(2*pi*addr/64)), with the
// positive peak clipped to 255 so it fits in 8 bits.
//   clk_in  : clock
//   addr_in : phase address (top LUT_ADDR_W bits of a voice phase)
//   amp_out : registered 8-bit amplitude
module sine_lut
  import synth_pkg::*;
(
  input  logic                  clk_in,
  input  logic [LUT_ADDR_W-1:0] addr_in,
  output logic [AMP_W-1:0]      amp_out
);

  localparam logic [AMP_W-1:0] TABLE [2**LUT_ADDR_W] = '{
    8'd128, 8'd140, 8'd152, 8'd165, 8'd176, 8'd188, 8'd199, 8'd209,
    8'd218, 8'd226, 8'd234, 8'd240, 8'd246, 8'd250, 8'd253, 8'd255,
    8'd255, 8'd255, 8'd253, 8'd250, 8'd246, 8'd240, 8'd234, 8'd226,
    8'd218, 8'd209, 8'd199, 8'd188, 8'd176, 8'd165, 8'd152, 8'd140,
    8'd128, 8'd115, 8'd103, 8'd90,  8'd79,  8'd67,  8'd56,  8'd46,
    8'd37,  8'd29,  8'd21,  8'd15,  8'd9,   8'd5,   8'd2,   8'd0,
    8'd0,   8'd0,   8'd2,   8'd5,   8'd9,   8'd15,  8'd21,  8'd29,
    8'd37,  8'd46,  8'd56,  8'd67,  8'd79,  8'd90,  8'd103, 8'd115
  };

  always_ff @(posedge clk_in) begin
    amp_out <= TABLE[addr_in];
  end

endmodule

// File: rtl/sine_voice_scheduler.sv
// Polyphonic sine voice scheduler. Holds a small voice table (active, key,
// phase, increment) and, on each sample strobe, sweeps every voice through
// the shared sine LUT one per cycle, summing the signed amplitudes of the
// active voices into mix_out.
//   clk_in          : clock (rising edge)
//   rst_in          : synchronous active-high reset
//   step_in         : sample strobe, starts one sweep from IDLE
//   note_valid_in   : note event offered
//   note_ready_out  : note event accepted (IDLE only)
//   note_on_in      : 1 = note-on, 0 = note-off
//   note_id_in      : key number
//   note_incr_in    : phase increment for note-on
//   mix_out         : summed signed voice amplitude, held between sweeps
//   mix_valid_out   : one-cycle pulse when mix_out updates
//   active_mask_out : per-voice allocated flags
//   drop_out        : pulse when a note-on found no free voice
//   overrun_out     : pulse when step_in arrived outside IDLE
module sine_voice_scheduler
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   step_in,
  input  logic                   note_valid_in,
  output logic                   note_ready_out,
  input  logic                   note_on_in,
  input  logic [6:0]             note_id_in,
  input  logic [PHASE_W-1:0]     note_incr_in,
  output logic signed [31:0]     mix_out,
  output logic                   mix_valid_out,
  output logic [NUM_VOICES-1:0]  active_mask_out,
  output logic                   drop_out,
  output logic                   overrun_out
);

  localparam int CNT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  // Offset-binary LUT amplitude to a sign-extended 32-bit sample.
  function automatic logic signed [31:0] amp_to_sample(input logic [AMP_W-1:0] amp);
    logic signed [AMP_W:0] d;
    d = $signed({1'b0, amp}) - $signed((AMP_W+1)'(AMP_MID));
    return {{(32-AMP_W-1){d[AMP_W]}}, d};
  endfunction

  state_t state, state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic                  live;
  logic                  sweep_en;
  logic                  sweep_last;

  logic [NUM_VOICES-1:0] active;
  logic [6:0]            id_r    [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_r [NUM_VOICES];
  logic [PHASE_W-1:0]    incr_r  [NUM_VOICES];

  logic                  note_fire;
  logic                  hit, free;
  logic [CNT_W-1:0]      hit_idx, free_idx;

  logic [LUT_ADDR_W-1:0] addr_p0;
  logic                  vld_p1;
  logic                  act_p1;
  logic [AMP_W-1:0]      amp_p1;
  logic signed [31:0]    acc_p1;
  logic signed [31:0]    acc_nxt;

  assign sweep_last      = (cnt == CNT_W'(NUM_VOICES-1));
  assign note_fire       = note_valid_in & note_ready_out;
  assign active_mask_out = active;

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step_in) state_nxt = SWEEP;
      SWEEP:   if (sweep_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. live keeps ready low for the cycle right after reset.
  always_comb begin
    note_ready_out = (state == IDLE) && live;
    mix_valid_out  = (state == DONE);
    sweep_en       = (state == SWEEP);
  end

  // Control registers: sweep counter and event pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      live        <= 1'b0;
      cnt         <= '0;
      overrun_out <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      live        <= 1'b1;
      cnt         <= sweep_en ? cnt + 1'b1 : '0;
      overrun_out <= step_in && (state != IDLE);
      vld_p1      <= sweep_en;
    end
  end

  // Note matching (key already sounding) and allocation (lowest free voice).
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int v = NUM_VOICES-1; v >= 0; v--) begin
      if (active[v] && (id_r[v] == note_id_in)) begin
        hit     = 1'b1;
        hit_idx = CNT_W'(v);
      end
      if (!active[v]) begin
        free     = 1'b1;
        free_idx = CNT_W'(v);
      end
    end
  end

  // Voice table. Note events only land in IDLE and phase advances only in
  // SWEEP, so the two writers never collide.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active   <= '0;
      drop_out <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        id_r[v]    <= '0;
        phase_r[v] <= '0;
        incr_r[v]  <= '0;
      end
    end else begin
      drop_out <= 1'b0;
      if (note_fire) begin
        if (note_on_in) begin
          if (hit) begin
            phase_r[hit_idx] <= '0;
            incr_r[hit_idx]  <= note_incr_in;
          end else if (free) begin
            active[free_idx]  <= 1'b1;
            id_r[free_idx]    <= note_id_in;
            phase_r[free_idx] <= '0;
            incr_r[free_idx]  <= note_incr_in;
          end else begin
            drop_out <= 1'b1;
          end
        end else if (hit) begin
          active[hit_idx] <= 1'b0;
        end
      end
      if (sweep_en && active[cnt]) begin
        phase_r[cnt] <= phase_r[cnt] + incr_r[cnt];
      end
    end
  end

  // Stage p0: present the current voice's phase to the LUT
  assign addr_p0 = phase_r[cnt][PHASE_W-1 -: LUT_ADDR_W];

  sine_lut u_lut (
    .clk_in  (clk_in),
    .addr_in (addr_p0),
    .amp_out (amp_p1)
  );

  always_ff @(posedge clk_in) begin
    act_p1 <= active[cnt];
  end

  // Stage p1: LUT amplitude returns; accumulate, publish on the last return
  assign acc_nxt = acc_p1 + (act_p1 ? amp_to_sample(amp_p1) : 32'sd0);

  always_ff @(posedge clk_in) begin
    if (state == IDLE)  acc_p1 <= '0;
    else if (vld_p1)    acc_p1 <= acc_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)               mix_out <= '0;
    else if (state == DRAIN)  mix_out <= acc_nxt;
  end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
module tb_sine_voice_scheduler;

  localparam int N  = 8;
  localparam int PW = 32;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 step_in;
  logic                 note_valid_in;
  logic                 note_ready_out;
  logic                 note_on_in;
  logic [6:0]           note_id_in;
  logic [PW-1:0]        note_incr_in;
  logic signed [31:0]   mix_out;
  logic                 mix_valid_out;
  logic [N-1:0]         active_mask_out;
  logic                 drop_out;
  logic                 overrun_out;

  int checks   = 0;
  int failures = 0;

  // Reference voice table
  bit        m_act [N];
  bit [6:0]  m_id  [N];
  bit [31:0] m_ph  [N];
  bit [31:0] m_inc [N];

  typedef struct {
    bit        on;
    bit [6:0]  id;
    bit [31:0] incr;
    bit [7:0]  mask;
    bit        drop;
  } vec_t;

  vec_t vt [14];

  sine_voice_scheduler #(.NUM_VOICES(N), .PHASE_W(PW)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .step_in         (step_in),
    .note_valid_in   (note_valid_in),
    .note_ready_out  (note_ready_out),
    .note_on_in      (note_on_in),
    .note_id_in      (note_id_in),
    .note_incr_in    (note_incr_in),
    .mix_out         (mix_out),
    .mix_valid_out   (mix_valid_out),
    .active_mask_out (active_mask_out),
    .drop_out        (drop_out),
    .overrun_out     (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Signed sine sample: floor(128*sin(2*pi*a/64)), peak clipped to 127.
  function automatic int lut_ref(input int a);
    real x;
    int  v;
    x = 128.0 * $sin(2.0 * 3.14159265358979 * a / 64.0);
    v = $rtoi($floor(x + 1.0e-9));
    if (v > 127) v = 127;
    return v;
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < N; v++) begin
      m_act[v] = 0; m_id[v] = 0; m_ph[v] = 0; m_inc[v] = 0;
    end
  endfunction

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m;
    for (int v = 0; v < N; v++) m[v] = m_act[v];
    return m;
  endfunction

  // Applies a note event; returns 1 when a note-on is dropped.
  function automatic bit model_note(input bit on, input bit [6:0] id, input bit [31:0] inc);
    int hit = -1;
    int fr  = -1;
    for (int v = 0; v < N; v++) begin
      if (hit < 0 && m_act[v] && m_id[v] == id) hit = v;
      if (fr < 0 && !m_act[v]) fr = v;
    end
    if (on) begin
      if (hit >= 0) begin
        m_ph[hit] = 0; m_inc[hit] = inc;
      end else if (fr >= 0) begin
        m_act[fr] = 1; m_id[fr] = id; m_ph[fr] = 0; m_inc[fr] = inc;
      end else begin
        return 1;
      end
    end else if (hit >= 0) begin
      m_act[hit] = 0;
    end
    return 0;
  endfunction

  // One sample: sum of active voices at their current phase, then advance.
  function automatic int model_sweep();
    int s = 0;
    for (int v = 0; v < N; v++) begin
      if (m_act[v]) begin
        s += lut_ref(int'(m_ph[v][31:26]));
        m_ph[v] += m_inc[v];
      end
    end
    return s;
  endfunction

  task automatic do_note(input bit on, input bit [6:0] id, input bit [31:0] inc);
    int  waitc = 0;
    bit  d;
    note_on_in    = on;
    note_id_in    = id;
    note_incr_in  = inc;
    note_valid_in = 1'b1;
    while (!note_ready_out && waitc < 50) begin
      tick();
      waitc++;
    end
    if (!note_ready_out) begin
      chk("note_ready_timeout", note_ready_out, 1);
      note_valid_in = 1'b0;
      return;
    end
    d = model_note(on, id, inc);
    tick();
    note_valid_in = 1'b0;
    chk("note_drop", drop_out, d);
    chk("note_mask", active_mask_out, model_mask());
  endtask

  task automatic do_step(input string nm, input bit use_hard, input int hard,
                         input bit with_note, input bit on, input bit [6:0] id,
                         input bit [31:0] inc);
    int exp;
    int early;
    bit d;
    d = 0;
    if (with_note) begin
      chk({nm, "_ready"}, note_ready_out, 1);
      note_on_in    = on;
      note_id_in    = id;
      note_incr_in  = inc;
      note_valid_in = 1'b1;
      d = model_note(on, id, inc);
    end
    exp = model_sweep();
    step_in = 1'b1;
    tick();
    step_in       = 1'b0;
    note_valid_in = 1'b0;
    if (with_note) begin
      chk({nm, "_drop"}, drop_out, d);
      chk({nm, "_mask"}, active_mask_out, model_mask());
    end
    early = 0;
    for (int c = 1; c < N + 2; c++) begin
      if (mix_valid_out) early++;
      tick();
    end
    chk({nm, "_early_valid"}, early, 0);
    chk({nm, "_valid"}, mix_valid_out, 1);
    chk({nm, "_mix"}, mix_out, exp);
    if (use_hard) chk({nm, "_mix_const"}, mix_out, hard);
    tick();
    chk({nm, "_valid_end"}, mix_valid_out, 0);
    chk({nm, "_hold"}, mix_out, exp);
  endtask

  initial begin
    int exp;
    int vcount;
    bit d;
    int exp4 [4];

    exp4 = '{0, 12, 24, 37};
    vt[0]  = '{1'b1, 7'd61, 32'h0200_0000, 8'h03, 1'b0};
    vt[1]  = '{1'b1, 7'd62, 32'h0300_0000, 8'h07, 1'b0};
    vt[2]  = '{1'b1, 7'd63, 32'h0500_0000, 8'h0F, 1'b0};
    vt[3]  = '{1'b1, 7'd64, 32'h0700_0000, 8'h1F, 1'b0};
    vt[4]  = '{1'b1, 7'd65, 32'h0B00_0000, 8'h3F, 1'b0};
    vt[5]  = '{1'b1, 7'd66, 32'h0D00_0000, 8'h7F, 1'b0};
    vt[6]  = '{1'b1, 7'd67, 32'h1100_0000, 8'hFF, 1'b0};
    vt[7]  = '{1'b1, 7'd68, 32'h1300_0000, 8'hFF, 1'b1};
    vt[8]  = '{1'b1, 7'd60, 32'h0800_0000, 8'hFF, 1'b0};
    vt[9]  = '{1'b0, 7'd99, 32'h0,         8'hFF, 1'b0};
    vt[10] = '{1'b0, 7'd60, 32'h0,         8'hFE, 1'b0};
    vt[11] = '{1'b1, 7'd70, 32'h0600_0000, 8'hFF, 1'b0};
    vt[12] = '{1'b0, 7'd63, 32'h0,         8'hF7, 1'b0};
    vt[13] = '{1'b0, 7'd61, 32'h0,         8'hF5, 1'b0};

    rst_in        = 1'b1;
    step_in       = 1'b0;
    note_valid_in = 1'b0;
    note_on_in    = 1'b0;
    note_id_in    = '0;
    note_incr_in  = '0;
    model_reset();

    tick();
    tick();
    chk("rst_ready", note_ready_out, 0);
    chk("rst_mask", active_mask_out, 0);
    chk("rst_mix", mix_out, 0);
    chk("rst_valid", mix_valid_out, 0);
    chk("rst_drop", drop_out, 0);
    chk("rst_overrun", overrun_out, 0);
    rst_in = 1'b0;
    tick();
    chk("ready_after_rst", note_ready_out, 1);

    // Empty table: zero mix after N+2 cycles
    do_step("empty", 1, 0, 0, 0, 0, 0);

    // Single voice ramp through the first LUT entries
    do_note(1, 7'd60, 32'h0400_0000);
    chk("single_mask", active_mask_out, 8'h01);
    for (int i = 0; i < 4; i++) do_step("ramp", 1, exp4[i], 0, 0, 0, 0);

    // Table-driven note events: fill, drop, retrigger, note-off
    for (int i = 0; i < 14; i++) begin
      if (i == 11) do_step("after_off", 0, 0, 0, 0, 0, 0);
      do_note(vt[i].on, vt[i].id, vt[i].incr);
      chk($sformatf("vec%0d_mask", i), active_mask_out, vt[i].mask);
      chk($sformatf("vec%0d_drop", i), drop_out, vt[i].drop);
    end
    do_step("after_vec", 0, 0, 0, 0, 0, 0);

    // Overrun step mid-sweep plus a note held until IDLE
    exp = model_sweep();
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    tick();
    note_on_in    = 1'b1;
    note_id_in    = 7'd80;
    note_incr_in  = 32'h0123_4567;
    note_valid_in = 1'b1;
    chk("ovr_ready_busy", note_ready_out, 0);
    tick();
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    chk("ovr_pulse", overrun_out, 1);
    tick();
    chk("ovr_pulse_end", overrun_out, 0);
    vcount = 0;
    for (int c = 5; c < 10; c++) begin
      if (mix_valid_out) vcount++;
      tick();
    end
    chk("ovr_no_early", vcount, 0);
    chk("ovr_valid", mix_valid_out, 1);
    chk("ovr_mix", mix_out, exp);
    chk("ovr_ready_done", note_ready_out, 0);
    tick();
    chk("ovr_ready_idle", note_ready_out, 1);
    chk("ovr_single_valid", mix_valid_out, 0);
    d = model_note(1'b1, 7'd80, 32'h0123_4567);
    tick();
    note_valid_in = 1'b0;
    chk("ovr_note_drop", drop_out, d);
    chk("ovr_note_mask", active_mask_out, model_mask());
    chk("ovr_note_mask_const", active_mask_out, 8'hF7);

    // Note and step in the same cycle: the sweep sees the new voice
    do_step("same_cycle", 0, 0, 1, 1'b1, 7'd81, 32'h0900_0000);
    chk("same_cycle_mask_const", active_mask_out, 8'hFF);

    // Reset in the middle of a sweep
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    repeat (4) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    model_reset();
    chk("midrst_ready", note_ready_out, 0);
    chk("midrst_mask", active_mask_out, 0);
    chk("midrst_mix", mix_out, 0);
    chk("midrst_valid", mix_valid_out, 0);
    vcount = 0;
    for (int c = 6; c <= 12; c++) begin
      tick();
      if (mix_valid_out) vcount++;
    end
    chk("midrst_no_valid", vcount, 0);
    do_step("post_rst", 1, 0, 0, 0, 0, 0);

    // Randomized notes and steps against the reference model
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0)
        do_note($urandom_range(0, 2) != 0, 7'($urandom_range(0, 11)), $urandom);
      else
        do_step("rnd", 0, 0, $urandom_range(0, 1) == 1, 1'b1,
                7'($urandom_range(0, 11)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
